// File: rtl/puf_burst_sequencer_if.sv
// ---------------------------------------------------------------------------
// puf_burst_sequencer_if
// Bundles the control, configuration, status and both AXI-Stream legs of the
// burst sequencer.
//   slave  modport : the sequencer itself
//   master modport : whoever drives it (host register file + radio + usrp2puf)
// Signals:
//   start, abort                 1-cycle control pulses
//   cfg_burst_len/gap_len/num_bursts  sequence configuration (CNT_WIDTH)
//   in_tdata/in_tvalid/in_tready      upstream IQ stream, tdata = {I,Q}
//   out_tdata/out_tvalid/out_tlast/out_tready  downstream stream
//   busy, done, cfg_err, burst_idx, discard_cnt  status
// Handshake: a transfer happens on a rising clk edge where tvalid && tready
// are both high; tdata/tlast are only meaningful while tvalid is high.
// ---------------------------------------------------------------------------
interface puf_burst_sequencer_if #(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
) ();
  logic                    start;
  logic                    abort;
  logic [CNT_WIDTH-1:0]    cfg_burst_len;
  logic [CNT_WIDTH-1:0]    cfg_gap_len;
  logic [CNT_WIDTH-1:0]    cfg_num_bursts;
  logic [2*DATA_WIDTH-1:0] in_tdata;
  logic                    in_tvalid;
  logic                    in_tready;
  logic [2*DATA_WIDTH-1:0] out_tdata;
  logic                    out_tvalid;
  logic                    out_tlast;
  logic                    out_tready;
  logic                    busy;
  logic                    done;
  logic                    cfg_err;
  logic [CNT_WIDTH-1:0]    burst_idx;
  logic [31:0]             discard_cnt;

  modport slave (
    input  start, abort, cfg_burst_len, cfg_gap_len, cfg_num_bursts,
    input  in_tdata, in_tvalid, out_tready,
    output in_tready, out_tdata, out_tvalid, out_tlast,
    output busy, done, cfg_err, burst_idx, discard_cnt
  );

  modport master (
    output start, abort, cfg_burst_len, cfg_gap_len, cfg_num_bursts,
    output in_tdata, in_tvalid, out_tready,
    input  in_tready, out_tdata, out_tvalid, out_tlast,
    input  busy, done, cfg_err, burst_idx, discard_cnt
  );
endinterface

// File: rtl/puf_burst_sequencer.sv
// ---------------------------------------------------------------------------
// puf_burst_sequencer
// Cuts the radio RX IQ stream into NUM_BURSTS packets of BURST_LEN samples
// (tlast on each packet's final beat) and drops GAP_LEN samples between
// packets. Started and configured by the host register file.
// Ports:
//   clk          clock
//   reset        asynchronous, active-low reset
//   bus          puf_burst_sequencer_if.slave (control, config, streams, status)
//   dbg_state_o  current FSM state (0 IDLE, 1 BURST, 2 GAP)
// Build option:
//   PUF_SEQ_DISCARD_CNT_EN  when defined, discard_cnt counts dropped GAP
//                           samples (saturating); otherwise it is tied to 0.
// Handshake: valid/ready AXI-Stream; a beat is tvalid && tready on a rising
// edge. During BURST the stream passes through combinationally, so
// in_tready follows out_tready and no sample is ever buffered or dropped.
// ---------------------------------------------------------------------------
module puf_burst_sequencer #(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  puf_burst_sequencer_if.slave bus,
  output logic [1:0]           dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BURST = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t               state_q;
  logic [CNT_WIDTH-1:0] burst_len_q;
  logic [CNT_WIDTH-1:0] gap_len_q;
  logic [CNT_WIDTH-1:0] num_bursts_q;
  logic [CNT_WIDTH-1:0] smp_cnt_q;
  logic [CNT_WIDTH-1:0] gap_cnt_q;
  logic [CNT_WIDTH-1:0] burst_idx_q;
  logic                 abort_pend_q;
  logic                 done_q;
  logic                 cfg_err_q;

  logic start_ok;
  logic start_bad;
  logic beat;
  logic tlast;
  logic final_burst;
  logic gap_last;

  // abort in the same cycle as start wins, so the start is not even rejected
  assign start_ok  = (state_q == S_IDLE) && bus.start && !bus.abort &&
                     (bus.cfg_burst_len != '0);
  assign start_bad = (state_q == S_IDLE) && bus.start && !bus.abort &&
                     (bus.cfg_burst_len == '0);

  assign beat        = bus.in_tvalid && bus.out_tready;
  // burst_len_q is never 0 once latched, so the subtraction cannot wrap
  assign tlast       = (state_q == S_BURST) &&
                       ((smp_cnt_q == burst_len_q - ONE) || abort_pend_q);
  assign final_burst = (num_bursts_q != '0) && (burst_idx_q == num_bursts_q - ONE);
  assign gap_last    = (gap_cnt_q == gap_len_q - ONE);

  always_comb begin
    bus.in_tready  = 1'b0;
    bus.out_tvalid = 1'b0;
    bus.out_tdata  = {(2*DATA_WIDTH){1'b0}};
    unique case (state_q)
      S_BURST: begin
        bus.in_tready  = bus.out_tready;
        bus.out_tvalid = bus.in_tvalid;
        bus.out_tdata  = bus.in_tdata;
      end
      S_GAP: begin
        bus.in_tready = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign bus.out_tlast = tlast;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = done_q;
  assign bus.cfg_err   = cfg_err_q;
  assign bus.burst_idx = burst_idx_q;
  assign dbg_state_o   = state_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      burst_len_q  <= '0;
      gap_len_q    <= '0;
      num_bursts_q <= '0;
      smp_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      burst_idx_q  <= '0;
      abort_pend_q <= 1'b0;
      done_q       <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start_ok) begin
            burst_len_q  <= bus.cfg_burst_len;
            gap_len_q    <= bus.cfg_gap_len;
            num_bursts_q <= bus.cfg_num_bursts;
            smp_cnt_q    <= '0;
            gap_cnt_q    <= '0;
            burst_idx_q  <= '0;
            abort_pend_q <= 1'b0;
            state_q      <= S_BURST;
          end else if (start_bad) begin
            cfg_err_q <= 1'b1;
          end
        end
        S_BURST: begin
          if (beat && tlast) begin
            smp_cnt_q    <= '0;
            gap_cnt_q    <= '0;
            abort_pend_q <= 1'b0;
            // A pending abort ends here; reaching the last burst counts as a
            // normal finish even if abort arrives on this very beat. An abort
            // landing on an ordinary packet boundary stops immediately since
            // the packet is already closed.
            if (abort_pend_q) begin
              state_q <= S_IDLE;
            end else if (final_burst) begin
              state_q <= S_IDLE;
              done_q  <= 1'b1;
            end else if (bus.abort) begin
              state_q <= S_IDLE;
            end else if (gap_len_q != '0) begin
              state_q <= S_GAP;
            end else begin
              burst_idx_q <= burst_idx_q + ONE;
            end
          end else begin
            if (beat) begin
              smp_cnt_q <= smp_cnt_q + ONE;
            end
            if (bus.abort) begin
              abort_pend_q <= 1'b1;
            end
          end
        end
        S_GAP: begin
          if (bus.abort) begin
            state_q <= S_IDLE;
          end else if (bus.in_tvalid) begin
            if (gap_last) begin
              state_q     <= S_BURST;
              burst_idx_q <= burst_idx_q + ONE;
            end else begin
              gap_cnt_q <= gap_cnt_q + ONE;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

`ifdef PUF_SEQ_DISCARD_CNT_EN
  logic [31:0] discard_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      discard_q <= '0;
    end else if (start_ok) begin
      discard_q <= '0;
    end else if ((state_q == S_GAP) && bus.in_tvalid && (discard_q != 32'hFFFF_FFFF)) begin
      discard_q <= discard_q + 32'd1;
    end
  end

  assign bus.discard_cnt = discard_q;
`else
  assign bus.discard_cnt = 32'd0;
`endif

endmodule
